// File: rtl/aes256_key_scheduler.sv
// Iterative AES-256 key expansion: one 128-bit round key per clock into a
// 15-entry register file, served through a combinational indexed read port.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform
  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign s = sbox_fn(a);

endmodule

module aes256_key_scheduler (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [255:0] key_in,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         keys_valid
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RK_W   = 128;
  localparam int unsigned KEY_W  = 256;
  localparam int unsigned N_RK   = 15;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t              state;
  logic [3:0]          k;
  logic [KEY_W-1:0]    win;
  logic [RK_W-1:0]     rf [N_RK];

  logic [WORD_W-1:0]   w_last;
  logic [WORD_W-1:0]   sb_in;
  logic [WORD_W-1:0]   sb_out;
  logic [WORD_W-1:0]   temp;
  logic [WORD_W-1:0]   n0, n1, n2, n3;
  logic [7:0]          rcon;
  logic [RK_W-1:0]     rk_new;

  // Round-key datapath; the same four S-boxes serve even (RotWord+Rcon) and odd rounds
  always_comb begin
    w_last = win[WORD_W-1:0];
    sb_in  = k[0] ? w_last : {w_last[23:0], w_last[31:24]};
    case (k[3:1])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
    temp   = k[0] ? sb_out : (sb_out ^ {rcon, 24'h0});
    n0     = win[255:224] ^ temp;
    n1     = win[223:192] ^ n0;
    n2     = win[191:160] ^ n1;
    n3     = win[159:128] ^ n2;
    rk_new = {n0, n1, n2, n3};
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sb_in[8*b +: 8]),
      .s (sb_out[8*b +: 8])
    );
  end

  // Control FSM and register file; key_load in any state (re)starts expansion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= 4'd2;
      win        <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int j = 0; j < int'(N_RK); j++) rf[j] <= '0;
    end else if (key_load) begin
      rf[0]      <= key_in[255:128];
      rf[1]      <= key_in[127:0];
      win        <= key_in;
      k          <= 4'd2;
      state      <= EXPAND;
      busy       <= 1'b1;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        EXPAND: begin
          rf[k] <= rk_new;
          win   <= {win[127:0], rk_new};
          k     <= k + 4'd1;
          if (k == 4'd14) begin
            state      <= DONE;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rk_out = '0;
    if (keys_valid && (rk_idx <= 4'd14)) rk_out = rf[rk_idx];
  end

endmodule

// File: tb/tb_aes256_key_scheduler.sv
// Randomized self-checking bench for aes256_key_scheduler against a
// table-driven FIPS-197 word-by-word key expansion model.

module tb_aes256_key_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load;
  logic [255:0] key_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         busy;
  logic         keys_valid;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] exp_rk [15];

  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  always #5 clk = ~clk;

  aes256_key_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_in     (key_in),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .busy       (busy),
    .keys_valid (keys_valid)
  );

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Textbook 60-word expansion, then grouped into 15 round keys
  task automatic compute_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [255:0] key);
    key_in   = key;
    key_load = 1'b1;
    step;
    key_load = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int cyc;
    cyc = 0;
    while (keys_valid !== 1'b1 && cyc < 40) begin
      check({tag, " busy"}, 128'(busy), 128'(1));
      step;
      cyc++;
    end
    check({tag, " latency"}, 128'(cyc), 128'(13));
    check({tag, " busy_done"}, 128'(busy), 128'(0));
  endtask

  // Only used where no clock edge can change state (idle, done or in reset)
  task automatic sweep(input string tag, input bit vld);
    logic [127:0] e;
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #1;
      e = (vld && i < 15) ? exp_rk[i] : 128'h0;
      check($sformatf("%s idx%0d", tag, i), rk_out, e);
    end
  endtask

  initial begin
    logic [255:0] rkey;
    logic [255:0] rkey2;
    rst_n    = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    rk_idx   = 4'd0;
    #12;
    check("rst busy", 128'(busy), 128'(0));
    check("rst keys_valid", 128'(keys_valid), 128'(0));
    check("rst rk_out", rk_out, 128'h0);

    // key_load held during reset must be ignored
    key_in   = KEY_A3;
    key_load = 1'b1;
    step;
    step;
    key_load = 1'b0;
    rst_n    = 1'b1;
    step;
    check("ignored load busy", 128'(busy), 128'(0));
    check("idle keys_valid", 128'(keys_valid), 128'(0));
    sweep("idle", 1'b0);

    // FIPS-197 A.3
    compute_model(KEY_A3);
    do_load(KEY_A3);
    check("a3 busy_e0", 128'(busy), 128'(1));
    check("a3 kv_e0", 128'(keys_valid), 128'(0));
    wait_valid("a3");
    sweep("a3", 1'b1);
    rk_idx = 4'd2;  #1;
    check("a3 rk2 vector", rk_out, 128'h9ba354118e6925afa51a8b5f2067fcde);
    rk_idx = 4'd14; #1;
    check("a3 rk14 vector", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);

    // Re-key from DONE with FIPS-197 C.3
    step;
    compute_model(KEY_C3);
    do_load(KEY_C3);
    check("rekey kv_drop", 128'(keys_valid), 128'(0));
    wait_valid("rekey");
    sweep("c3", 1'b1);
    rk_idx = 4'd0;  #1;
    check("c3 rk0 vector", rk_out, 128'h000102030405060708090a0b0c0d0e0f);
    rk_idx = 4'd1;  #1;
    check("c3 rk1 vector", rk_out, 128'h101112131415161718191a1b1c1d1e1f);
    rk_idx = 4'd14; #1;
    check("c3 rk14 vector", rk_out, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Reload mid-EXPAND on cycle 5
    step;
    do_load(KEY_A3);
    repeat (4) begin
      check("reload kv_low", 128'(keys_valid), 128'(0));
      step;
    end
    do_load(KEY_C3);
    wait_valid("reload");
    sweep("reload", 1'b1);

    // Reset mid-EXPAND at cycle 7
    step;
    do_load(KEY_A3);
    repeat (6) step;
    rk_idx = 4'd0;
    rst_n  = 1'b0;
    #1;
    check("midrst busy", 128'(busy), 128'(0));
    check("midrst keys_valid", 128'(keys_valid), 128'(0));
    check("midrst rk_out", rk_out, 128'h0);
    sweep("in_reset", 1'b0);
    step;
    rst_n = 1'b1;
    step;
    compute_model(KEY_A3);
    do_load(KEY_A3);
    wait_valid("post_rst");
    sweep("post_rst", 1'b1);

    // Random keys, sometimes aborted by a second random key mid-expansion
    for (int t = 0; t < 6; t++) begin
      step;
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      compute_model(rkey);
      do_load(rkey);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 11)) begin
          check("rand abort kv_low", 128'(keys_valid), 128'(0));
          step;
        end
        rkey2 = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        compute_model(rkey2);
        do_load(rkey2);
      end
      wait_valid($sformatf("rand%0d", t));
      sweep($sformatf("rand%0d", t), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
